row_scan_sequencer: RTL and testbench

ROW_SCAN_SEQUENCER -- requirements
Module: row_scan_sequencer

---
 rtl/row_scan_sequencer.sv | 167 ++++++++++++++++
 tb/tb_row_scan_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_scan_sequencer.sv
// Row-scan sequencer for a multiplexed LED driver. It loads dot correction, then alternates grayscale shift, latch/swap and PWM run per row.
// shift_start is registered and fires on the first cycle of each shift phase; a late shift_done stalls the display blanked.
module row_scan_sequencer #(
  parameter int ROWS      = 6,
  parameter int GSCLK_DIV = 8,
  parameter int GS_STEPS  = 4096
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            dc_reload,
  input  logic            shift_done,
  output logic            shift_start,
  output logic            shift_mode,
  output logic [2:0]      shift_row,
  output logic            led_mode,
  output logic            led_xlat,
  output logic            led_blank,
  output logic            led_gsclk,
  output logic [ROWS-1:0] row_sel,
  output logic [7:0]      frame_count,
  output logic            overrun
);

  typedef enum logic [2:0] {
    IDLE,
    DC_SHIFT,
    DC_LATCH,
    PRELOAD,
    SWAP,
    RUN,
    STALL
  } state_t;

  localparam int RUN_CYCLES = GS_STEPS * GSCLK_DIV;
  localparam int CW         = $clog2(RUN_CYCLES);
  localparam int GSB        = $clog2(GSCLK_DIV) - 1;

  localparam logic [CW-1:0]   CNT_LAST = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [2:0]      LAST_ROW = 3'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_ONE  = {{(ROWS-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            line_ready_q, line_ready_d;
  logic [2:0]      cur_row_q, cur_row_d;
  logic [2:0]      next_row_q, next_row_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [7:0]      frame_q, frame_d;
  logic            overrun_q, overrun_d;
  logic            start_q, start_d;
  logic            mode_q, mode_d;
  logic [2:0]      srow_q, srow_d;
  logic            dc_enter;
  logic            reload_due;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      line_ready_q <= 1'b0;
      cur_row_q    <= 3'd0;
      next_row_q   <= 3'd0;
      row_sel_q    <= '0;
      frame_q      <= 8'd0;
      overrun_q    <= 1'b0;
      start_q      <= 1'b0;
      mode_q       <= 1'b0;
      srow_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      line_ready_q <= line_ready_d;
      cur_row_q    <= cur_row_d;
      next_row_q   <= next_row_d;
      row_sel_q    <= row_sel_d;
      frame_q      <= frame_d;
      overrun_q    <= overrun_d;
      start_q      <= start_d;
      mode_q       <= mode_d;
      srow_q       <= srow_d;
    end
  end

  // A pending reload is honoured only once the last row of the frame has been displayed.
  assign reload_due = pending_q && (cur_row_q == LAST_ROW);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_ready_d = line_ready_q;
    cur_row_d    = cur_row_q;
    next_row_d   = next_row_q;
    row_sel_d    = row_sel_q;
    frame_d      = frame_q;
    overrun_d    = overrun_q;
    start_d      = 1'b0;
    mode_d       = mode_q;
    srow_d       = srow_q;

    case (state_q)
      IDLE:     state_d = DC_SHIFT;
      DC_SHIFT: if (shift_done) state_d = DC_LATCH;
      DC_LATCH: state_d = PRELOAD;
      PRELOAD:  if (shift_done) state_d = SWAP;
      SWAP: begin
        state_d    = RUN;
        row_sel_d  = ROW_ONE << next_row_q;
        cur_row_d  = next_row_q;
        next_row_d = (next_row_q == LAST_ROW) ? 3'd0 : 3'(next_row_q + 3'd1);
        if ((cur_row_q == LAST_ROW) && (next_row_q == 3'd0)) begin
          frame_d = 8'(frame_q + 8'd1);
        end
      end
      RUN: begin
        cnt_d = CW'(cnt_q + CNT_ONE);
        if (shift_done) line_ready_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (line_ready_q || shift_done) begin
            line_ready_d = 1'b0;
            state_d      = reload_due ? DC_SHIFT : SWAP;
          end else begin
            overrun_d = 1'b1;
            state_d   = STALL;
          end
        end
      end
      STALL:   if (shift_done) state_d = reload_due ? DC_SHIFT : SWAP;
      default: state_d = IDLE;
    endcase

    // Dot-correction and preload phases keep the panel dark and restart the row scan at 0.
    if ((state_d == DC_SHIFT) || (state_d == DC_LATCH) || (state_d == PRELOAD)) begin
      next_row_d = 3'd0;
      row_sel_d  = '0;
    end

    dc_enter = (state_d == DC_SHIFT) && (state_q != DC_SHIFT);
    if (dc_enter) begin
      start_d = 1'b1;
      mode_d  = 1'b1;
      srow_d  = 3'd0;
    end else if ((state_q == DC_LATCH) || (state_q == SWAP)) begin
      start_d = 1'b1;
      mode_d  = 1'b0;
      srow_d  = next_row_d;
    end
  end

  assign pending_d   = dc_reload | (pending_q & ~dc_enter);

  assign shift_start = start_q;
  assign shift_mode  = mode_q;
  assign led_mode    = mode_q;
  assign shift_row   = srow_q;
  assign led_xlat    = (state_q == DC_LATCH) || (state_q == SWAP);
  assign led_blank   = (state_q != RUN);
  assign led_gsclk   = (state_q == RUN) && cnt_q[GSB];
  assign row_sel     = row_sel_q;
  assign frame_count = frame_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed bench for row_scan_sequencer with ROWS=3, GSCLK_DIV=2, GS_STEPS=4 and a delayed shift_done responder.
module tb_row_scan_sequencer;

  localparam int ROWS = 3;

  logic            clock;
  logic            reset;
  logic            dc_reload;
  logic            shift_done;
  logic            resp_done;
  logic            spur;
  logic            shift_start;
  logic            shift_mode;
  logic [2:0]      shift_row;
  logic            led_mode;
  logic            led_xlat;
  logic            led_blank;
  logic            led_gsclk;
  logic [ROWS-1:0] row_sel;
  logic [7:0]      frame_count;
  logic            overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int done_dly = 5;
  int rem      = 0;
  int n, gs_rise, blank_lo, patt_err, done_k, xl_k, stall_bad, starts;
  logic prev_gs;

  assign shift_done = resp_done | spur;

  row_scan_sequencer #(.ROWS(ROWS), .GSCLK_DIV(2), .GS_STEPS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .dc_reload   (dc_reload),
    .shift_done  (shift_done),
    .shift_start (shift_start),
    .shift_mode  (shift_mode),
    .shift_row   (shift_row),
    .led_mode    (led_mode),
    .led_xlat    (led_xlat),
    .led_blank   (led_blank),
    .led_gsclk   (led_gsclk),
    .row_sel     (row_sel),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Shift engine model: shift_done pulses done_dly cycles after each shift_start.
  initial begin
    resp_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      resp_done = 1'b0;
      if (reset) begin
        rem = 0;
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) resp_done = 1'b1;
        end
        if (shift_start) rem = done_dly;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_now(input int which);
    case (which)
      0:       return shift_start;
      1:       return led_xlat;
      default: return shift_start && shift_mode;
    endcase
  endfunction

  // Returns the number of cycles until the signal is seen, or -1 if the budget runs out.
  task automatic wait_sig(input int which, input int maxc, output int cnt);
    cnt = -1;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if (sig_now(which)) begin
        cnt = c;
        break;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    dc_reload = 1'b0;
    spur      = 1'b0;
    repeat (3) tick();

    chk("rst_blank",   32'(led_blank),   32'd1);
    chk("rst_start",   32'(shift_start), 32'd0);
    chk("rst_mode",    32'(shift_mode),  32'd0);
    chk("rst_ledmode", 32'(led_mode),    32'd0);
    chk("rst_row",     32'(shift_row),   32'd0);
    chk("rst_xlat",    32'(led_xlat),    32'd0);
    chk("rst_gsclk",   32'(led_gsclk),   32'd0);
    chk("rst_rowsel",  32'(row_sel),     32'd0);
    chk("rst_frame",   32'(frame_count), 32'd0);
    chk("rst_overrun", 32'(overrun),     32'd0);

    // Startup: dot-correction shift, latch, preload of row 0, swap.
    reset = 1'b0;
    wait_sig(0, 10, n);
    chk("idle_len",    32'(n),          32'd1);
    chk("dc_mode",     32'(shift_mode), 32'd1);
    chk("dc_row",      32'(shift_row),  32'd0);
    chk("dc_rowsel",   32'(row_sel),    32'd0);
    chk("dc_blank",    32'(led_blank),  32'd1);
    wait_sig(1, 20, n);
    chk("dclatch_wait", 32'(n),          32'd6);
    chk("dclatch_mode", 32'(shift_mode), 32'd1);
    chk("dclatch_led",  32'(led_mode),   32'd1);
    tick();
    chk("pre_start",   32'(shift_start), 32'd1);
    chk("pre_mode",    32'(shift_mode),  32'd0);
    chk("pre_row",     32'(shift_row),   32'd0);
    chk("pre_blank",   32'(led_blank),   32'd1);
    wait_sig(1, 20, n);
    chk("swap_wait",   32'(n),          32'd6);
    chk("swap_rowsel", 32'(row_sel),    32'd0);
    chk("swap_blank",  32'(led_blank),  32'd1);
    tick();
    chk("run0_rowsel", 32'(row_sel),     32'b001);
    chk("run0_start",  32'(shift_start), 32'd1);
    chk("run0_row",    32'(shift_row),   32'd1);
    chk("run0_frame",  32'(frame_count), 32'd0);

    // One RUN window: 8 cycles, gsclk low first, 4 pulses.
    gs_rise = 0; blank_lo = 0; patt_err = 0; prev_gs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (led_gsclk && !prev_gs) gs_rise++;
      if (!led_blank) blank_lo++;
      if (led_gsclk !== 1'((i % 2))) patt_err++;
      prev_gs = led_gsclk;
      tick();
    end
    chk("run_gs_pulses", 32'(gs_rise),  32'd4);
    chk("run_blank_lo",  32'(blank_lo), 32'd8);
    chk("run_gs_patt",   32'(patt_err), 32'd0);
    chk("run_end_xlat",  32'(led_xlat), 32'd1);

    // Rest of the first frame and wrap to row 0.
    tick();
    chk("run1_rowsel", 32'(row_sel),   32'b010);
    chk("run1_row",    32'(shift_row), 32'd2);
    wait_sig(1, 20, n);
    chk("swap1_wait",  32'(n),         32'd8);
    tick();
    chk("run2_rowsel", 32'(row_sel),     32'b100);
    chk("run2_row",    32'(shift_row),   32'd0);
    wait_sig(1, 20, n);
    chk("swap2_frame", 32'(frame_count), 32'd0);
    tick();
    chk("wrap_rowsel",  32'(row_sel),     32'b001);
    chk("wrap_frame",   32'(frame_count), 32'd1);
    chk("wrap_overrun", 32'(overrun),     32'd0);

    // Spurious shift_done in SWAP, then a late shift for the next line.
    wait_sig(1, 20, n);
    chk("swap3_wait", 32'(n), 32'd8);
    spur     = 1'b1;
    done_dly = 12;
    tick();
    spur = 1'b0;
    chk("spur_rowsel",  32'(row_sel),     32'b010);
    chk("spur_blank",   32'(led_blank),   32'd0);
    chk("spur_xlat",    32'(led_xlat),    32'd0);
    chk("spur_start",   32'(shift_start), 32'd1);
    chk("spur_overrun", 32'(overrun),     32'd0);
    dc_reload = 1'b1;
    tick();
    dc_reload = 1'b0;
    repeat (6) tick();
    chk("late_run_end_ovr", 32'(overrun), 32'd0);
    tick();
    chk("stall_overrun", 32'(overrun),   32'd1);
    chk("stall_blank",   32'(led_blank), 32'd1);
    chk("stall_gsclk",   32'(led_gsclk), 32'd0);
    done_k = -1; xl_k = -1; stall_bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (shift_done) done_k = k;
      if (led_xlat) begin
        xl_k = k;
        break;
      end
      if (!led_blank || led_gsclk) stall_bad++;
      tick();
    end
    chk("stall_done_at", 32'(done_k),    32'd4);
    chk("stall_swap_at", 32'(xl_k),      32'd5);
    chk("stall_held",    32'(stall_bad), 32'd0);
    done_dly = 5;
    tick();
    chk("row2_rowsel", 32'(row_sel),     32'b100);
    chk("row2_frame",  32'(frame_count), 32'd1);

    // Pending reload takes effect after row 2's RUN.
    wait_sig(2, 20, n);
    chk("rl_dc_wait",  32'(n),          32'd8);
    chk("rl_dc_row",   32'(shift_row),  32'd0);
    chk("rl_rowsel",   32'(row_sel),    32'd0);
    chk("rl_blank",    32'(led_blank),  32'd1);
    wait_sig(1, 20, n);
    chk("rl_latch_wait", 32'(n),          32'd6);
    chk("rl_latch_mode", 32'(shift_mode), 32'd1);
    tick();
    chk("rl_pre_start", 32'(shift_start), 32'd1);
    chk("rl_pre_mode",  32'(shift_mode),  32'd0);
    chk("rl_pre_row",   32'(shift_row),   32'd0);
    wait_sig(1, 20, n);
    chk("rl_swap_wait", 32'(n), 32'd6);
    tick();
    chk("rl_rowsel",  32'(row_sel),     32'b001);
    chk("rl_frame",   32'(frame_count), 32'd2);
    chk("rl_overrun", 32'(overrun),     32'd1);

    // Asynchronous reset in the middle of RUN.
    tick();
    tick();
    chk("pre_rst_blank", 32'(led_blank), 32'd0);
    reset = 1'b1;
    #1;
    chk("arst_blank",   32'(led_blank),   32'd1);
    chk("arst_rowsel",  32'(row_sel),     32'd0);
    chk("arst_frame",   32'(frame_count), 32'd0);
    chk("arst_overrun", 32'(overrun),     32'd0);
    chk("arst_start",   32'(shift_start), 32'd0);
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (shift_start) starts++;
    end
    chk("rst_no_starts", 32'(starts), 32'd0);
    reset = 1'b0;
    wait_sig(0, 10, n);
    chk("rerun_idle_len", 32'(n),          32'd1);
    chk("rerun_mode",     32'(shift_mode), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
